// File: rtl/fifo_async.sv
// Single-clock FIFO with binary pointers mirrored in Gray code and registered flags/read data.
// Optional sticky wr_overflow/rd_underflow outputs are enabled with FIFO_ASYNC_ERR_FLAGS_EN.
module fifo_async #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             wr_clk,
   input  logic             w_rst,
   input  logic             wr_inc,
   input  logic [DSIZE-1:0] d_input,
   input  logic             rd_inc,
   output logic [DSIZE-1:0] d_output,
   output logic             wr_full,
`ifdef FIFO_ASYNC_ERR_FLAGS_EN
   output logic             rd_empty,
   output logic             wr_overflow,
   output logic             rd_underflow
`else
   output logic             rd_empty
`endif
);

   localparam int DEPTH = 1 << ASIZE;
   localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

   logic [DSIZE-1:0] mem [DEPTH];

   logic [ASIZE:0]   wptr_q, wptr_d;
   logic [ASIZE:0]   rptr_q, rptr_d;
   logic [ASIZE:0]   wgray_q, wgray_d;
   logic [ASIZE:0]   rgray_q, rgray_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic [DSIZE-1:0] dout_q;
   logic             we, re;

   // Accept decisions use the registered flags, so a request against a full/empty FIFO
   // is dropped even if the opposite side frees or fills a slot on the same edge.
   always_comb begin
      we      = wr_inc & ~full_q;
      re      = rd_inc & ~empty_q;
      wptr_d  = we ? (wptr_q + PTR_ONE) : wptr_q;
      rptr_d  = re ? (rptr_q + PTR_ONE) : rptr_q;
      wgray_d = wptr_d ^ (wptr_d >> 1);
      rgray_d = rptr_d ^ (rptr_d >> 1);
      empty_d = (wgray_d == rgray_d);
      full_d  = (wgray_d == {~rgray_d[ASIZE:ASIZE-1], rgray_d[ASIZE-2:0]});
   end

   always_ff @(posedge wr_clk or posedge w_rst) begin
      if (w_rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         wgray_q <= '0;
         rgray_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         dout_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         wgray_q <= wgray_d;
         rgray_q <= rgray_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         if (re) begin
            dout_q <= mem[rptr_q[ASIZE-1:0]];
         end
      end
   end

   // Storage is deliberately left unreset; the pointers alone define valid contents.
   always_ff @(posedge wr_clk) begin
      if (we) begin
         mem[wptr_q[ASIZE-1:0]] <= d_input;
      end
   end

   assign d_output = dout_q;
   assign wr_full  = full_q;
   assign rd_empty = empty_q;

`ifdef FIFO_ASYNC_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge wr_clk or posedge w_rst) begin
      if (w_rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_q | (wr_inc & full_q);
         underflow_q <= underflow_q | (rd_inc & empty_q);
      end
   end

   assign wr_overflow  = overflow_q;
   assign rd_underflow = underflow_q;
`else
   logic unusedGray;
   assign unusedGray = ^{wgray_q, rgray_q};
`endif

`ifdef FIFO_ASYNC_ERR_FLAGS_EN
   logic unusedGrayErr;
   assign unusedGrayErr = ^{wgray_q, rgray_q};
`endif

endmodule

// File: tb/tb_fifo_async.sv
// Scoreboard bench for fifo_async: stimulus pushes expected read data into a queue,
// and a negedge monitor pops and compares it against d_output.
module tb_fifo_async;

   localparam int DSIZE = 8;
   localparam int ASIZE = 4;
   localparam int DEPTH = 16;

   typedef struct {
      int               due;
      logic [DSIZE-1:0] data;
   } expEntry_t;

   logic             wrClk = 1'b0;
   logic             wRst;
   logic             wrInc;
   logic             rdInc;
   logic [DSIZE-1:0] dInput;
   logic [DSIZE-1:0] dOutput;
   logic             wrFull;
   logic             rdEmpty;
`ifdef FIFO_ASYNC_ERR_FLAGS_EN
   logic             wrOverflow;
   logic             rdUnderflow;
`endif

   int checks = 0;
   int errors = 0;
   int cycleCount = 0;

   logic [DSIZE-1:0] modelQ[$];
   expEntry_t        expQ[$];

   fifo_async #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
      .wr_clk      (wrClk),
      .w_rst       (wRst),
      .wr_inc      (wrInc),
      .d_input     (dInput),
      .rd_inc      (rdInc),
      .d_output    (dOutput),
      .wr_full     (wrFull),
`ifdef FIFO_ASYNC_ERR_FLAGS_EN
      .rd_empty    (rdEmpty),
      .wr_overflow (wrOverflow),
      .rd_underflow(rdUnderflow)
`else
      .rd_empty    (rdEmpty)
`endif
   );

   always #5 wrClk = ~wrClk;

   always @(posedge wrClk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   // Called at a negedge; drives one cycle of requests, updates the reference model,
   // then returns at the following negedge after checking the flags.
   task automatic applyStimulus(input logic wr, input logic [DSIZE-1:0] d, input logic rd);
      bit weOk, reOk;
      weOk   = wr && (modelQ.size() < DEPTH);
      reOk   = rd && (modelQ.size() > 0);
      wrInc  = wr;
      dInput = d;
      rdInc  = rd;
      if (reOk) expQ.push_back('{cycleCount + 1, modelQ.pop_front()});
      if (weOk) modelQ.push_back(d);
      @(posedge wrClk);
      @(negedge wrClk);
      wrInc = 1'b0;
      rdInc = 1'b0;
      checkOutput("rd_empty", {31'd0, rdEmpty}, {31'd0, modelQ.size() == 0});
      checkOutput("wr_full", {31'd0, wrFull}, {31'd0, modelQ.size() == DEPTH});
   endtask

   // Monitor: entries become due one edge after the read was issued.
   initial begin
      expEntry_t e;
      forever begin
         @(negedge wrClk);
         while (expQ.size() > 0 && expQ[0].due <= cycleCount) begin
            e = expQ.pop_front();
            checkOutput($sformatf("read_data_due%0d", e.due), {24'd0, dOutput}, {24'd0, e.data});
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      wRst   = 1'b1;
      wrInc  = 1'b0;
      rdInc  = 1'b0;
      dInput = '0;

      // Reset then idle
      repeat (2) @(negedge wrClk);
      checkOutput("reset_rd_empty", {31'd0, rdEmpty}, 32'd1);
      checkOutput("reset_wr_full", {31'd0, wrFull}, 32'd0);
      checkOutput("reset_d_output", {24'd0, dOutput}, 32'd0);
      wRst = 1'b0;
      @(negedge wrClk);
      checkOutput("idle_rd_empty", {31'd0, rdEmpty}, 32'd1);
      checkOutput("idle_d_output", {24'd0, dOutput}, 32'd0);

      // Fill then drain, including a dropped 17th write
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput("fill_full", {31'd0, wrFull}, 32'd1);
      applyStimulus(1'b1, 8'hAA, 1'b0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("drain_empty", {31'd0, rdEmpty}, 32'd1);
      checkOutput("drain_last", {24'd0, dOutput}, 32'h0F);

      // Wrap-around streaming with both requests held high
      for (int i = 0; i < 60; i++) applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Simultaneous read and write at full
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i * 3 + 1), 1'b0);
      applyStimulus(1'b1, 8'h55, 1'b1);
      checkOutput("full_rw_oldest", {24'd0, dOutput}, 32'h01);
      checkOutput("full_rw_not_full", {31'd0, wrFull}, 32'd0);
      while (modelQ.size() > 0) applyStimulus(1'b0, 8'h00, 1'b1);

      // Simultaneous read and write at empty
      applyStimulus(1'b1, 8'h77, 1'b1);
      checkOutput("empty_rw_not_empty", {31'd0, rdEmpty}, 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Mid-stream reset
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
      #2 wRst = 1'b1;
      #1;
      checkOutput("midreset_rd_empty", {31'd0, rdEmpty}, 32'd1);
      checkOutput("midreset_wr_full", {31'd0, wrFull}, 32'd0);
      checkOutput("midreset_d_output", {24'd0, dOutput}, 32'd0);
      modelQ.delete();
      expQ.delete();
      @(negedge wrClk);
      wRst = 1'b0;
      applyStimulus(1'b1, 8'h3C, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("post_reset_read", {24'd0, dOutput}, 32'h3C);

`ifdef FIFO_ASYNC_ERR_FLAGS_EN
      checkOutput("err_clear_ovf", {31'd0, wrOverflow}, 32'd0);
      checkOutput("err_clear_udf", {31'd0, rdUnderflow}, 32'd0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
      applyStimulus(1'b1, 8'hEE, 1'b0);
      checkOutput("err_overflow_set", {31'd0, wrOverflow}, 32'd1);
      checkOutput("err_underflow_quiet", {31'd0, rdUnderflow}, 32'd0);
      while (modelQ.size() > 0) applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("err_underflow_set", {31'd0, rdUnderflow}, 32'd1);
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("err_overflow_sticky", {31'd0, wrOverflow}, 32'd1);
      checkOutput("err_underflow_sticky", {31'd0, rdUnderflow}, 32'd1);
      wRst = 1'b1;
      #1;
      checkOutput("err_overflow_reset", {31'd0, wrOverflow}, 32'd0);
      checkOutput("err_underflow_reset", {31'd0, rdUnderflow}, 32'd0);
      modelQ.delete();
      expQ.delete();
      @(negedge wrClk);
      wRst = 1'b0;
`endif

      repeat (2) @(negedge wrClk);
      checkOutput("scoreboard_drained", expQ.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
